// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory read arbiters: FSM state encoding and
// default parameter values.
package mem_arb_pkg;

  // Default parameter values
  localparam int unsigned DEF_NUM_REQ      = 2;
  localparam int unsigned DEF_WORD_SIZE    = 8;
  localparam int unsigned DEF_ADDRESS_SIZE = 4;
  localparam int unsigned DEF_TIMEOUT      = 15;

  // Timeout counter width; TIMEOUT is limited to 1..255
  localparam int unsigned TMO_CNT_W = 8;

  // Arbiter FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/mem_read_arbiter_rr_select.sv
// Combinational round-robin picker. Searches req from (last_grant+1) mod
// NUM_REQ upward with wrap and reports the first set bit.
//   req        : request vector
//   last_grant : index of the previously served requester
//   found_c    : at least one request bit is set
//   index_c    : index of the winning requester (0 when none)
module rr_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       found_c,
  output logic [$clog2(NUM_REQ)-1:0] index_c
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  // First hit wins, so candidates are visited in priority order
  always_comb begin
    int unsigned cand;
    found_c = 1'b0;
    index_c = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_grant) + k) % NUM_REQ;
      if (!found_c && (|(req & (NUM_REQ'(1) << cand)))) begin
        found_c = 1'b1;
        index_c = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one handshaked memory read port between
// NUM_REQ requesters, with a per-transaction timeout.
//   clock, reset : clock and asynchronous active-high reset
//   req_valid    : per-requester read request (level, held until req_done)
//   req_addr     : packed addresses, requester i at [i*ADDRESS_SIZE +: ADDRESS_SIZE]
//   req_done     : one-hot one-cycle completion pulse
//   req_data     : read word, valid with req_done
//   req_error    : transaction timed out (req_data = 0)
//   mem_r_en     : memory read enable, high while the read is outstanding
//   mem_r_addr   : latched address of the granted request
//   mem_r_data   : memory read data
//   mem_r_ready  : memory ready/valid
//   busy         : arbiter not idle
//   grant_id     : current/last granted requester
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
  parameter int unsigned ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0]   req_addr,
  output logic [NUM_REQ-1:0]                req_done,
  output logic [WORD_SIZE-1:0]              req_data,
  output logic                              req_error,
  output logic                              mem_r_en,
  output logic [ADDRESS_SIZE-1:0]           mem_r_addr,
  input  logic [WORD_SIZE-1:0]              mem_r_data,
  input  logic                              mem_r_ready,
  output logic                              busy,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [1:0]              state, state_nxt;
  logic [ID_W-1:0]         last_grant, last_grant_nxt;
  logic [ID_W-1:0]         grant_id_nxt;
  logic [ADDRESS_SIZE-1:0] mem_r_addr_nxt;
  logic                    mem_r_en_nxt;
  logic [TMO_CNT_W-1:0]    tmo_cnt, tmo_cnt_nxt, tmo_cnt_inc;
  logic                    err_flag, err_flag_nxt;
  logic [WORD_SIZE-1:0]    req_data_nxt;
  logic [NUM_REQ-1:0]      req_done_nxt;
  logic                    req_error_nxt;
  logic                    busy_nxt;

  logic                    win_found_c;
  logic [ID_W-1:0]         win_idx_c;

  // Round-robin winner among the current requests
  rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .req        (req_valid),
    .last_grant (last_grant),
    .found_c    (win_found_c),
    .index_c    (win_idx_c)
  );

  assign tmo_cnt_inc = tmo_cnt + TMO_CNT_W'(1);

  // Next-state and next-output logic; every registered output is computed
  // here so nothing combinational reaches the ports
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_id_nxt   = grant_id;
    mem_r_addr_nxt = mem_r_addr;
    mem_r_en_nxt   = 1'b0;
    tmo_cnt_nxt    = tmo_cnt;
    err_flag_nxt   = err_flag;
    req_data_nxt   = req_data;
    req_done_nxt   = '0;
    req_error_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (win_found_c) begin
          grant_id_nxt   = win_idx_c;
          mem_r_addr_nxt = ADDRESS_SIZE'(req_addr >> (32'(win_idx_c) * ADDRESS_SIZE));
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        // Ready is ignored here: it may be left over from the previous read
        mem_r_en_nxt = 1'b1;
        tmo_cnt_nxt  = '0;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (mem_r_ready) begin
          req_data_nxt = mem_r_data;
          err_flag_nxt = 1'b0;
          state_nxt    = DONE;
        end else if (tmo_cnt_inc == TMO_CNT_W'(TIMEOUT)) begin
          req_data_nxt = '0;
          err_flag_nxt = 1'b1;
          tmo_cnt_nxt  = tmo_cnt_inc;
          state_nxt    = DONE;
        end else begin
          tmo_cnt_nxt  = tmo_cnt_inc;
          mem_r_en_nxt = 1'b1;
        end
      end
      DONE: begin
        req_done_nxt   = NUM_REQ'(1) << grant_id;
        req_error_nxt  = err_flag;
        last_grant_nxt = grant_id;
        state_nxt      = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      mem_r_addr <= '0;
      mem_r_en   <= 1'b0;
      tmo_cnt    <= '0;
      err_flag   <= 1'b0;
      req_data   <= '0;
      req_done   <= '0;
      req_error  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_id   <= grant_id_nxt;
      mem_r_addr <= mem_r_addr_nxt;
      mem_r_en   <= mem_r_en_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      err_flag   <= err_flag_nxt;
      req_data   <= req_data_nxt;
      req_done   <= req_done_nxt;
      req_error  <= req_error_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed self-checking bench for mem_read_arbiter with a small
// behavioural memory (configurable latency, stuck-low or forced ready).
module tb_mem_read_arbiter;

  localparam int unsigned NUM_REQ      = 2;
  localparam int unsigned WORD_SIZE    = 8;
  localparam int unsigned ADDRESS_SIZE = 4;
  localparam int unsigned TIMEOUT      = 4;

  logic                            clock = 1'b0;
  logic                            reset = 1'b1;
  logic [NUM_REQ-1:0]              req_valid = '0;
  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]              req_done;
  logic [WORD_SIZE-1:0]            req_data;
  logic                            req_error;
  logic                            mem_r_en;
  logic [ADDRESS_SIZE-1:0]         mem_r_addr;
  logic [WORD_SIZE-1:0]            mem_r_data = '0;
  logic                            mem_r_ready = 1'b0;
  logic                            busy;
  logic [$clog2(NUM_REQ)-1:0]      grant_id;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mem_read_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .WORD_SIZE    (WORD_SIZE),
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_done    (req_done),
    .req_data    (req_data),
    .req_error   (req_error),
    .mem_r_en    (mem_r_en),
    .mem_r_addr  (mem_r_addr),
    .mem_r_data  (mem_r_data),
    .mem_r_ready (mem_r_ready),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural memory
  logic [7:0] mem_array [16];
  int         lat_cnt    = 0;
  int         mem_lat    = 2;
  bit         mem_stuck  = 1'b0;
  bit         mem_force  = 1'b0;
  logic [7:0] force_data = 8'h3C;

  always @(posedge clock) begin
    if (mem_force) begin
      mem_r_ready <= 1'b1;
      mem_r_data  <= force_data;
    end else if (mem_r_en) begin
      lat_cnt <= lat_cnt + 1;
      if (!mem_stuck && (lat_cnt + 1 >= mem_lat)) begin
        mem_r_ready <= 1'b1;
        mem_r_data  <= mem_array[mem_r_addr];
      end else begin
        mem_r_ready <= 1'b0;
      end
    end else begin
      lat_cnt     <= 0;
      mem_r_ready <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Enable gap and single-cycle done pulse monitor
  int   gap       = 0;
  bit   seen_en   = 1'b0;
  logic prev_en   = 1'b0;
  logic [NUM_REQ-1:0] prev_done = '0;

  always @(negedge clock) begin
    if (mem_r_en && !prev_en && seen_en) check_eq("en_gap_ge2", 32'(gap >= 2), 32'd1);
    if (mem_r_en) begin
      gap     = 0;
      seen_en = 1'b1;
    end else begin
      gap++;
    end
    if (req_done != '0 && prev_done != '0) check_eq("done_one_cycle", 32'(prev_done), 32'd0);
    prev_done = req_done;
    prev_en   = mem_r_en;
  end

  // One transaction: wait for grant, optionally rewrite req_addr, wait for done
  task automatic run_txn(input int exp_id, input logic [3:0] exp_addr, input logic [7:0] exp_data,
                         input logic exp_err, input int exp_lat,
                         input logic [7:0] addr_after, input bit drop);
    int t0;
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!busy && n < 50);
    check_eq("grant_busy", 32'(busy), 32'd1);
    t0 = cyc;
    check_eq("grant_id", 32'(grant_id), 32'(exp_id));
    check_eq("r_addr", 32'(mem_r_addr), 32'(exp_addr));
    req_addr = addr_after;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (req_done == '0) check_eq("r_addr_hold", 32'(mem_r_addr), 32'(exp_addr));
    end while (req_done == '0 && n < 50);
    check_eq("done_vec", 32'(req_done), 32'd1 << exp_id);
    check_eq("data", 32'(req_data), 32'(exp_data));
    check_eq("error", 32'(req_error), 32'(exp_err));
    check_eq("latency", 32'(cyc - t0), 32'(exp_lat));
    check_eq("en_low_at_done", 32'(mem_r_en), 32'd0);
    if (drop) req_valid = req_valid & ~(2'(1) << exp_id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem_array[i] = 8'(8'h10 + i);
    mem_array[5] = 8'hA7;

    // Reset values
    repeat (2) @(negedge clock);
    check_eq("rst_en", 32'(mem_r_en), 32'd0);
    check_eq("rst_addr", 32'(mem_r_addr), 32'd0);
    check_eq("rst_done", 32'(req_done), 32'd0);
    check_eq("rst_data", 32'(req_data), 32'd0);
    check_eq("rst_error", 32'(req_error), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_grant", 32'(grant_id), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single request, memory ready 2 cycles after enable
    req_addr  = 8'h05;
    req_valid = 2'b01;
    run_txn(0, 4'h5, 8'hA7, 1'b0, 5, 8'h05, 1'b1);

    // Address changes after grant: read still uses 3
    req_addr  = 8'h30;
    req_valid = 2'b10;
    run_txn(1, 4'h3, 8'h13, 1'b0, 5, 8'h90, 1'b1);

    // Contention: grants alternate
    req_addr  = 8'h72;
    req_valid = 2'b11;
    run_txn(0, 4'h2, 8'h12, 1'b0, 5, 8'h72, 1'b0);
    run_txn(1, 4'h7, 8'h17, 1'b0, 5, 8'h72, 1'b0);
    run_txn(0, 4'h2, 8'h12, 1'b0, 5, 8'h72, 1'b0);
    run_txn(1, 4'h7, 8'h17, 1'b0, 5, 8'h72, 1'b1);
    req_valid = '0;

    // Timeout on requester 0, then requester 1 served normally
    mem_stuck = 1'b1;
    req_addr  = 8'h48;
    req_valid = 2'b11;
    run_txn(0, 4'h8, 8'h00, 1'b1, 6, 8'h48, 1'b1);
    mem_stuck = 1'b0;
    run_txn(1, 4'h4, 8'h14, 1'b0, 5, 8'h48, 1'b1);
    req_valid = '0;

    // Stale ready held high: captured at first WAIT cycle, not in ISSUE
    mem_force = 1'b1;
    req_addr  = 8'h01;
    req_valid = 2'b01;
    run_txn(0, 4'h1, 8'h3C, 1'b0, 3, 8'h01, 1'b1);
    mem_force = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clock);

    // Reset in WAIT: enable and busy drop at once, no done, requester 0 wins next
    mem_stuck = 1'b1;
    req_addr  = 8'h60;
    req_valid = 2'b10;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!busy && n < 50);
    check_eq("rstw_busy", 32'(busy), 32'd1);
    @(negedge clock);
    check_eq("rstw_en_in_wait", 32'(mem_r_en), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("rstw_en", 32'(mem_r_en), 32'd0);
    check_eq("rstw_busy_low", 32'(busy), 32'd0);
    check_eq("rstw_done", 32'(req_done), 32'd0);
    req_valid = '0;
    mem_stuck = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_eq("rstw_no_done", 32'(req_done), 32'd0);
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check_eq("rstw_no_done_after", 32'(req_done), 32'd0);
    end
    req_addr  = 8'h65;
    req_valid = 2'b11;
    run_txn(0, 4'h5, 8'hA7, 1'b0, 5, 8'h65, 1'b1);
    req_valid = '0;
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Round-robin arbiter that shares the single handshaked memory read port (r_en / r_addr / r_data / r_ready) between NUM_REQ requesters, e.g. two sequencer instances reading the same pattern memory. It sits between the requesters and the memory. It:
- serialises their reads and latches each request's address;
- drives the memory read enable for one transaction at a time;
- returns the read word to the granted requester with a one-cycle done pulse;
- bounds every transaction with a timeout.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- WORD_SIZE, 8, memory word width
- ADDRESS_SIZE, 4, memory address width
- TIMEOUT, 15, max WAIT cycles before a read is abandoned (1..255)

Ports (reset is asynchronous, active-high; clock is `clock`):
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester read request, level, held until its req_done
- req_addr  input  NUM_REQ*ADDRESS_SIZE  packed addresses, requester i at bits [i*ADDRESS_SIZE +: ADDRESS_SIZE]
- req_done  output  NUM_REQ  one-hot, one-cycle completion pulse
- req_data  output  WORD_SIZE  read word, valid while any req_done bit is high
- req_error  output  1  high with req_done when the transaction timed out (req_data = 0)
- mem_r_en  output  1  memory read enable, high for the whole transaction
- mem_r_addr  output  ADDRESS_SIZE  latched address of the granted request
- mem_r_data  input  WORD_SIZE  memory read data
- mem_r_ready  input  1  memory ready/valid
- busy  output  1  high in any state other than IDLE
- grant_id  output  $clog2(NUM_REQ)  index of the current/last granted requester

## Operation
The state machine has four states: IDLE, ISSUE, WAIT, DONE.

- **IDLE:** if any req_valid bit is high:
  - select the winner by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap;
  - latch grant_id and the winner's req_addr into mem_r_addr;
  - go to ISSUE.
- **ISSUE (1 cycle):**
  - mem_r_en = 1;
  - mem_r_ready is ignored, because the memory may still show ready from the previous transaction;
  - clear the timeout counter; go to WAIT.
- **WAIT:** mem_r_en = 1.
  - First cycle with mem_r_ready = 1: capture mem_r_data into req_data and go to DONE with error = 0.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, go to DONE with error = 1 and req_data = 0.
- **DONE (1 cycle):**
  - mem_r_en = 0;
  - req_done[grant_id] = 1, and req_error reflects the error flag;
  - last_grant ← grant_id; go to IDLE.

Rules:
- The address is latched at grant. Changing req_addr afterwards has no effect on the current read.
- If req_valid[grant_id] drops mid-transaction, the transaction still completes and the done pulse is still issued.
- A requester whose req_valid is still high in the IDLE cycle after its DONE is treated as a new request. It competes in round-robin, so the other requesters get priority.
- mem_r_en is always low for at least 2 cycles (DONE + IDLE) between transactions, so the memory sees a fresh rising edge.
- Only bits [NUM_REQ-1:0] are considered. No request means the block stays in IDLE with outputs held.

## Timing
- **Reset values:** state IDLE; mem_r_en 0; mem_r_addr 0; req_done 0; req_data 0; req_error 0; busy 0; grant_id 0; last_grant NUM_REQ-1, so requester 0 wins first; timeout counter 0.
- **Asynchronous reset mid-transaction:** mem_r_en drops immediately, no done pulse is issued, and the outstanding request is lost. Requesters must re-request.
- **Latency:** req_valid sampled in IDLE at edge 0. Then:
  - mem_r_en goes high after edge 1;
  - the earliest ready is sampled at edge 2;
  - req_done is high after edge 3.
  - Minimum cycle-to-cycle throughput is 4 cycles per read.
- **Timeout:** with mem_r_ready stuck low, req_done and req_error assert TIMEOUT+2 cycles after the grant edge.
- **Registering:** all outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package mem_arb_pkg holds the state encoding constants (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3) and the default parameter values.
- One sub-module, rr_select: a combinational round-robin picker. Inputs are request vector and last_grant; outputs are found and index. It is reusable by the other arbiters.
- The top level contains the FSM, the address/data latches and the timeout counter.

## Test plan
- **Single request:** req_valid = 01, req_addr[0] = 4'h5, memory ready 2 cycles after r_en with data 8'hA7 -> mem_r_addr = 5, req_done = 01 one cycle, req_data = A7, req_error = 0, mem_r_en low afterwards.
- **Contention:** both req_valid held high continuously -> grants alternate 0,1,0,1 over four transactions. Each transaction has one done pulse, and mem_r_en is low for ≥2 cycles between transactions.
- **Timeout:** TIMEOUT = 4, mem_r_ready forced low -> req_done and req_error assert 6 cycles after the grant edge, req_data = 0, then the next requester is served normally.
- **Stale ready:** mem_r_ready held high from the previous read -> ISSUE ignores it, and data is captured no earlier than the first WAIT cycle.
- **Reset mid-WAIT:** assert reset in WAIT -> mem_r_en = 0 and busy = 0 within the same time step, no req_done pulse, and the first grant after reset goes to requester 0.
- **Address change after grant:** req_addr changes from 3 to 9 after the grant -> mem_r_addr stays 3 for the whole transaction.
